// File: rtl/freq_meter_pkg.sv
// Shared types and constants for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {IDLE, GATE, DONE} fm_state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Brings an asynchronous input into clk_in through a flop chain and flags its rising edges.
module sync_edge_det
    import freq_meter_pkg::*;
(
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic rise
);

    // Bits [SYNC_STAGES-1:0] are the synchronizer; the top bit is the edge-history flop.
    logic [SYNC_STAGES:0] chain_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= {chain_reg[SYNC_STAGES-1:0], d};
        end
    end

    assign rise = chain_reg[SYNC_STAGES-1] & ~chain_reg[SYNC_STAGES];

endmodule

// File: rtl/freq_meter.sv
// Counts sig_in rising edges over a GATE_CYCLES window of clk_in and reports the count.
// Define FREQ_METER_AUTO_EN for continuous back-to-back windows after the first start.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int FREC_IN     = 100000000,
    parameter int GATE_CYCLES = FREC_IN,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 start,
    output logic                 busy,
    output logic                 valid,
    output logic [CNT_WIDTH-1:0] freq_out,
    output logic                 overflow
);

    localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    fm_state_t            state_reg, state_next;
    logic [GW-1:0]        gate_cnt_reg, gate_cnt_next;
    logic [CNT_WIDTH-1:0] edge_cnt_reg, edge_cnt_next;
    logic                 sat_reg, sat_next;
    logic [CNT_WIDTH-1:0] freq_out_reg, freq_out_next;
    logic                 overflow_reg, overflow_next;
    logic                 valid_reg, valid_next;
    logic                 rise;
    logic [CNT_WIDTH-1:0] edge_cnt_inc;
    logic                 sat_inc;

    sync_edge_det u_sync (
        .clk_in (clk_in),
        .reset  (reset),
        .d      (sig_in),
        .rise   (rise)
    );

    // Saturating edge count including this cycle's rise.
    assign edge_cnt_inc = (rise && edge_cnt_reg != CNT_MAX) ? edge_cnt_reg + 1'b1 : edge_cnt_reg;
    assign sat_inc      = sat_reg | (rise && edge_cnt_reg == CNT_MAX);

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg    <= IDLE;
            gate_cnt_reg <= '0;
            edge_cnt_reg <= '0;
            sat_reg      <= 1'b0;
            freq_out_reg <= '0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            gate_cnt_reg <= gate_cnt_next;
            edge_cnt_reg <= edge_cnt_next;
            sat_reg      <= sat_next;
            freq_out_reg <= freq_out_next;
            overflow_reg <= overflow_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        gate_cnt_next = gate_cnt_reg;
        edge_cnt_next = edge_cnt_reg;
        sat_next      = sat_reg;
        freq_out_next = freq_out_reg;
        overflow_next = overflow_reg;
        valid_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    gate_cnt_next = '0;
                    edge_cnt_next = '0;
                    sat_next      = 1'b0;
                    state_next    = GATE;
                end
            end
            GATE: begin
                gate_cnt_next = gate_cnt_reg + 1'b1;
                edge_cnt_next = edge_cnt_inc;
                sat_next      = sat_inc;
                // Result is loaded on entry to DONE so it is visible alongside valid.
                if (gate_cnt_reg == GATE_LAST) begin
                    state_next    = DONE;
                    freq_out_next = edge_cnt_inc;
                    overflow_next = sat_inc;
                    valid_next    = 1'b1;
                end
            end
            DONE: begin
`ifdef FREQ_METER_AUTO_EN
                gate_cnt_next = '0;
                edge_cnt_next = '0;
                sat_next      = 1'b0;
                state_next    = GATE;
`else
                state_next    = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy     = (state_reg != IDLE);
    assign valid    = valid_reg;
    assign freq_out = freq_out_reg;
    assign overflow = overflow_reg;

endmodule
